// File: rtl/imem_port_arbiter.sv
// Round-robin arbiter sharing a single-port synchronous-read instruction memory between fetch and loader.
// Define IMEM_ARB_STATS_EN to add saturating grant/conflict/error counters.
module imem_port_arbiter #(
  parameter logic [31:0] BASE_ADDR   = 32'h0100_0000,
  parameter int unsigned DEPTH_WORDS = 512
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_req_valid,
  output logic        fetch_req_ready,
  input  logic [29:0] fetch_addr,
  output logic        fetch_rsp_valid,
  output logic [31:0] fetch_rsp_data,
  output logic        fetch_rsp_err,
  input  logic        ld_req_valid,
  output logic        ld_req_ready,
  input  logic        ld_req_we,
  input  logic [29:0] ld_addr,
  input  logic [31:0] ld_wdata,
  input  logic        ld_lock,
  output logic        ld_rsp_valid,
  output logic [31:0] ld_rsp_data,
  output logic        ld_rsp_err,
  output logic [29:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
`ifdef IMEM_ARB_STATS_EN
  ,
  output logic [31:0] stat_fetch_grants,
  output logic [31:0] stat_ld_grants,
  output logic [31:0] stat_conflicts,
  output logic [31:0] stat_errors
`endif
);

  localparam logic [30:0] LO_W = {1'b0, BASE_ADDR[31:2]};
  localparam logic [30:0] HI_W = LO_W + 31'(DEPTH_WORDS);

  // Compared at 31 bits so the upper bound cannot wrap at the top of the address space.
  function automatic logic in_range(input logic [29:0] addr);
    logic [30:0] a;
    a = {1'b0, addr};
    return (a >= LO_W) && (a < HI_W);
  endfunction

  logic fetch_gnt, ld_gnt, gnt_in_range;
  logic rr_q, rr_d;  // 1 = loader won the last contested grant
  logic fetch_vld_p1_q, fetch_vld_p1_d;
  logic ld_vld_p1_q, ld_vld_p1_d;
  logic we_p1_q, we_p1_d;
  logic err_p1_q, err_p1_d;

  always_comb begin
    fetch_gnt = 1'b0;
    ld_gnt    = 1'b0;
    rr_d      = rr_q;
    if (ld_lock) begin
      ld_gnt = ld_req_valid;
    end else if (fetch_req_valid && ld_req_valid) begin
      fetch_gnt = rr_q;
      ld_gnt    = ~rr_q;
      rr_d      = ~rr_q;
    end else begin
      fetch_gnt = fetch_req_valid;
      ld_gnt    = ld_req_valid;
    end
  end

  assign fetch_req_ready = fetch_gnt;
  assign ld_req_ready    = ld_gnt;

  assign mem_addr     = ld_gnt ? ld_addr : fetch_addr;
  assign gnt_in_range = in_range(mem_addr);
  assign mem_we       = ld_gnt & ld_req_we & gnt_in_range;
  assign mem_wdata    = ld_wdata;

  always_comb begin
    fetch_vld_p1_d = fetch_gnt;
    ld_vld_p1_d    = ld_gnt;
    we_p1_d        = ld_gnt & ld_req_we;
    err_p1_d       = (fetch_gnt | ld_gnt) & ~gnt_in_range;
  end

  // Stage p1: grant bookkeeping, aligned with the memory's read latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q           <= 1'b1;
      fetch_vld_p1_q <= 1'b0;
      ld_vld_p1_q    <= 1'b0;
      we_p1_q        <= 1'b0;
      err_p1_q       <= 1'b0;
    end else begin
      rr_q           <= rr_d;
      fetch_vld_p1_q <= fetch_vld_p1_d;
      ld_vld_p1_q    <= ld_vld_p1_d;
      we_p1_q        <= we_p1_d;
      err_p1_q       <= err_p1_d;
    end
  end

  assign fetch_rsp_valid = fetch_vld_p1_q;
  assign fetch_rsp_err   = fetch_vld_p1_q & err_p1_q;
  assign fetch_rsp_data  = (fetch_vld_p1_q && !err_p1_q) ? mem_rdata : 32'h0;
  assign ld_rsp_valid    = ld_vld_p1_q;
  assign ld_rsp_err      = ld_vld_p1_q & err_p1_q;
  assign ld_rsp_data     = (ld_vld_p1_q && !err_p1_q && !we_p1_q) ? mem_rdata : 32'h0;

`ifdef IMEM_ARB_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && v != 32'hFFFF_FFFF) ? v + 32'd1 : v;
  endfunction

  logic [31:0] fetch_grants_q, fetch_grants_d;
  logic [31:0] ld_grants_q, ld_grants_d;
  logic [31:0] conflicts_q, conflicts_d;
  logic [31:0] errors_q, errors_d;

  always_comb begin
    fetch_grants_d = sat_inc(fetch_grants_q, fetch_gnt);
    ld_grants_d    = sat_inc(ld_grants_q, ld_gnt);
    conflicts_d    = sat_inc(conflicts_q, (fetch_req_valid & ~fetch_gnt) | (ld_req_valid & ~ld_gnt));
    errors_d       = sat_inc(errors_q, (fetch_gnt | ld_gnt) & ~gnt_in_range);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_grants_q <= 32'h0;
      ld_grants_q    <= 32'h0;
      conflicts_q    <= 32'h0;
      errors_q       <= 32'h0;
    end else begin
      fetch_grants_q <= fetch_grants_d;
      ld_grants_q    <= ld_grants_d;
      conflicts_q    <= conflicts_d;
      errors_q       <= errors_d;
    end
  end

  assign stat_fetch_grants = fetch_grants_q;
  assign stat_ld_grants    = ld_grants_q;
  assign stat_conflicts    = conflicts_q;
  assign stat_errors       = errors_q;
`endif

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed plus randomized bench for imem_port_arbiter with a memory stub and a shadow-memory reference model.
module tb_imem_port_arbiter;
  localparam logic [29:0] B     = 30'h0400000;
  localparam int          DEPTH = 512;

  logic clk = 1'b0;
  logic rst_n;
  logic fetch_req_valid, fetch_req_ready, fetch_rsp_valid, fetch_rsp_err;
  logic [29:0] fetch_addr, ld_addr, mem_addr;
  logic [31:0] fetch_rsp_data, ld_wdata, ld_rsp_data, mem_wdata, mem_rdata;
  logic ld_req_valid, ld_req_ready, ld_req_we, ld_lock, ld_rsp_valid, ld_rsp_err, mem_we;

  imem_port_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .fetch_req_valid(fetch_req_valid), .fetch_req_ready(fetch_req_ready), .fetch_addr(fetch_addr),
    .fetch_rsp_valid(fetch_rsp_valid), .fetch_rsp_data(fetch_rsp_data), .fetch_rsp_err(fetch_rsp_err),
    .ld_req_valid(ld_req_valid), .ld_req_ready(ld_req_ready), .ld_req_we(ld_req_we),
    .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_lock(ld_lock),
    .ld_rsp_valid(ld_rsp_valid), .ld_rsp_data(ld_rsp_data), .ld_rsp_err(ld_rsp_err),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic bit tb_in(input logic [29:0] a);
    longint unsigned v;
    v = longint'(a);
    return (v >= longint'(B)) && (v < longint'(B) + DEPTH);
  endfunction

  function automatic logic [31:0] init_val(input int i);
    return (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_0000;
  endfunction

  // Memory stub: synchronous read, one-cycle latency, preloaded on its first clock.
  logic [31:0] tbmem [DEPTH];
  bit preloaded = 1'b0;
  always @(posedge clk) begin
    if (!preloaded) begin
      for (int i = 0; i < DEPTH; i++) tbmem[i] <= init_val(i);
      preloaded <= 1'b1;
    end else if (mem_we && tb_in(mem_addr)) begin
      tbmem[int'(mem_addr - B)] <= mem_wdata;
    end
    mem_rdata <= tb_in(mem_addr) ? tbmem[int'(mem_addr - B)] : 32'hBAD0_BAD0;
  end

  int checks = 0;
  int failures = 0;

  logic [31:0] ref_mem [DEPTH];
  bit last_ld;  // loader won the last contested grant
  bit exp_fv, exp_fe, exp_lv, exp_le;
  logic [31:0] exp_fd, exp_ld;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    last_ld = 1'b1;
    exp_fv = 0; exp_fe = 0; exp_lv = 0; exp_le = 0;
    exp_fd = 0; exp_ld = 0;
  endtask

  task automatic check_rsp();
    chk("fetch_rsp_valid", fetch_rsp_valid, exp_fv);
    chk("fetch_rsp_err", fetch_rsp_err, exp_fe);
    chk("fetch_rsp_data", fetch_rsp_data, exp_fd);
    chk("ld_rsp_valid", ld_rsp_valid, exp_lv);
    chk("ld_rsp_err", ld_rsp_err, exp_le);
    chk("ld_rsp_data", ld_rsp_data, exp_ld);
  endtask

  // One clock of stimulus; called and returning at posedge+1.
  task automatic step(input bit fv, input logic [29:0] fa, input bit lv, input bit lwe,
                      input logic [29:0] la, input logic [31:0] lwd, input bit lk);
    bit gf, gl;
    fetch_req_valid = fv; fetch_addr = fa;
    ld_req_valid = lv; ld_req_we = lwe; ld_addr = la; ld_wdata = lwd; ld_lock = lk;
    #1;
    gf = 0; gl = 0;
    if (lk) gl = lv;
    else if (fv && lv) begin
      if (last_ld) gf = 1; else gl = 1;
      last_ld = gl;
    end else begin
      gf = fv; gl = lv;
    end
    chk("fetch_req_ready", fetch_req_ready, gf);
    chk("ld_req_ready", ld_req_ready, gl);
    chk("mem_addr", mem_addr, gl ? la : fa);
    chk("mem_we", mem_we, gl && lwe && tb_in(la));
    if (gl && lwe && tb_in(la)) chk("mem_wdata", mem_wdata, lwd);
    check_rsp();
    exp_fv = gf;
    exp_fe = gf && !tb_in(fa);
    exp_fd = (gf && tb_in(fa)) ? ref_mem[int'(fa - B)] : 32'h0;
    exp_lv = gl;
    exp_le = gl && !tb_in(la);
    exp_ld = (gl && tb_in(la) && !lwe) ? ref_mem[int'(la - B)] : 32'h0;
    if (gl && lwe && tb_in(la)) ref_mem[int'(la - B)] = lwd;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    step(0, B, 0, 0, B, 32'h0, 0);
  endtask

  function automatic logic [29:0] rand_addr();
    case ($urandom_range(0, 9))
      0: return B - 30'd1;
      1: return B + 30'(DEPTH - 1);
      2: return B + 30'(DEPTH);
      3: return 30'h3FFF_FFFF;
      4: return 30'h0;
      default: return B + 30'($urandom_range(0, 31));
    endcase
  endfunction

  initial begin
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_val(i);
    model_reset();
    rst_n = 1'b0;
    fetch_req_valid = 0; fetch_addr = B; ld_req_valid = 0; ld_req_we = 0;
    ld_addr = B; ld_wdata = 0; ld_lock = 0;
    repeat (2) @(posedge clk);
    #1;
    check_rsp();
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Contention right after reset: fetch, ld, fetch, ld
    for (int i = 0; i < 4; i++) step(1, B + 30'(i), 1, 0, B + 30'(8 + i), 32'h0, 0);
    idle();

    // Fetch-only stream
    for (int i = 0; i < 3; i++) step(1, B + 30'(i), 0, 0, B, 32'h0, 0);
    idle();

    // Loader write then read of the same word
    step(0, B, 1, 1, B + 30'h10, 32'hDEAD_BEEF, 0);
    step(0, B, 1, 0, B + 30'h10, 32'h0, 0);
    idle();
    chk("ld_readback", ref_mem[16], 32'hDEAD_BEEF);

    // Range boundaries
    step(0, B, 1, 1, B + 30'h200, 32'h1234_5678, 0);
    step(1, B - 30'd1, 0, 0, B, 32'h0, 0);
    step(1, B + 30'h1FF, 1, 0, 30'h3FFF_FFFF, 32'h0, 0);
    idle();

    // ld_lock during fetch streaming
    step(1, B + 30'd1, 0, 0, B, 32'h0, 0);
    step(1, B + 30'd2, 1, 0, B + 30'd3, 32'h0, 1);
    step(1, B + 30'd2, 0, 0, B, 32'h0, 1);
    step(1, B + 30'd2, 0, 0, B, 32'h0, 0);
    idle();

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 3) != 0), rand_addr(), ($urandom_range(0, 2) != 0),
           $urandom_range(0, 1) == 1, rand_addr(), $urandom(), ($urandom_range(0, 6) == 0));
    end
    idle();

    // Reset asserted the cycle after a grant
    step(1, B + 30'd4, 1, 0, B + 30'd5, 32'h0, 0);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_rsp();
    fetch_req_valid = 1; ld_req_valid = 1; ld_req_we = 0; ld_lock = 0;
    #1;
    chk("rst_fetch_ready", fetch_req_ready, 1'b1);
    chk("rst_ld_ready", ld_req_ready, 1'b0);
    @(posedge clk); #1;
    check_rsp();
    rst_n = 1'b1;
    step(1, B + 30'd6, 1, 0, B + 30'd7, 32'h0, 0);
    step(1, B + 30'd8, 1, 0, B + 30'd9, 32'h0, 0);
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/imem_port_arbiter.md
Name: imem_port_arbiter

Overview:
Shares the single-port, synchronous-read instruction memory between two requesters: the CPU fetch stage and the program loader/debug port. The loader port can read and write; the fetch port is read-only. One request is granted per cycle, with round-robin fairness and an optional loader-exclusive lock. Each granted request gets a 1-cycle-latency response, and out-of-range addresses return an error without touching memory.

Parameters:
BASE_ADDR, 32'h0100_0000, byte base address of the instruction memory; must be word aligned.
DEPTH_WORDS, 512, number of 32-bit words in the memory; the valid word range is [BASE_ADDR/4, BASE_ADDR/4+DEPTH_WORDS).

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
fetch_req_valid  in  1  fetch read request.
fetch_req_ready  out  1  fetch request accepted this cycle; combinational.
fetch_addr  in  30  fetch word address [31:2].
fetch_rsp_valid  out  1  fetch response pulse.
fetch_rsp_data  out  32  fetch read data.
fetch_rsp_err  out  1  fetch address was out of range.
ld_req_valid  in  1  loader request.
ld_req_ready  out  1  loader request accepted this cycle; combinational.
ld_req_we  in  1  1 = write, 0 = read.
ld_addr  in  30  loader word address [31:2].
ld_wdata  in  32  loader write data.
ld_lock  in  1  loader exclusive mode; blocks fetch grants.
ld_rsp_valid  out  1  loader response pulse.
ld_rsp_data  out  32  loader read data; 0 for writes and errors.
ld_rsp_err  out  1  loader address was out of range.
mem_addr  out  30  word address to memory; the memory registers it on clk.
mem_we  out  1  memory write enable.
mem_wdata  out  32  memory write data.
mem_rdata  in  32  memory read data; valid the cycle after the address is presented.

Behaviour:
- Transfer occurs when req_valid and req_ready are both high on a rising edge. The ready outputs depend only on valid inputs, ld_lock and the rr pointer.
- Arbitration with ld_lock=1:
  - fetch_req_ready=0.
  - ld_req_ready=ld_req_valid.
- Arbitration with ld_lock=0, only one requester valid: that requester wins.
- Arbitration with ld_lock=0, both requesters valid: the requester that did not win the last contested grant wins. The rr pointer updates only on contested grants.
- A ready output is never high when its own valid is low.
- Memory drive:
  - mem_addr is the granted address; with no grant it defaults to fetch_addr.
  - mem_we = ld grant AND ld_req_we AND in_range.
  - mem_wdata = ld_wdata.
  - An out-of-range grant never asserts mem_we.
- Range check: in_range = (addr >= BASE_ADDR[31:2]) AND (addr < BASE_ADDR[31:2]+DEPTH_WORDS). The comparison is computed at 31 bits so no wrap occurs at the top of the address space.
- Response pipeline: registered owner, we and err flags.
  - In cycle N+1 after a grant in cycle N, the owner's rsp_valid=1 for exactly one cycle.
  - Read: data = mem_rdata, err=0.
  - Write: data = 0, err=0.
  - Out of range: data = 0, err=1.
  - The non-owner's rsp_valid=0.
- No response backpressure; requesters must sink responses.
- Back-to-back grants every cycle are supported, giving full throughput. Responses keep request order per port.
- Data outputs: rsp_data is 0 whenever rsp_valid=0.
- Simultaneous events:
  - ld_lock rising with a fetch response in flight: that response is still delivered next cycle.
  - A loader write followed by a loader read of the same address in the next cycle returns the new data.
- Reset values (asynchronous, while rst_n=0):
  - rsp_valid, rsp_err and rsp_data outputs are 0.
  - The rr pointer points at the loader, so fetch wins the first contested grant.
  - In-flight responses are discarded and are never issued after reset release.
- Combinational outputs during reset: ready outputs follow the arbitration rules. Requests accepted while rst_n=0 are dropped.

Optional Feature:
Macro IMEM_ARB_STATS_EN.
- Defined: adds outputs stat_fetch_grants[31:0], stat_ld_grants[31:0], stat_conflicts[31:0] and stat_errors[31:0].
  - All counters reset to 0 and saturate at 32'hFFFF_FFFF.
  - stat_conflicts counts cycles where a valid requester was not granted, including fetch blocked by ld_lock.
  - stat_errors counts out-of-range grants.
- Undefined: these ports and counters do not exist. All other behaviour is identical.

Test Plan:
- Fetch-only stream: fetch_addr = 0x0400000, 0x0400001, 0x0400002 on consecutive cycles -> fetch_req_ready=1 each cycle; fetch_rsp_valid on cycles 1-3 carrying the preloaded mem words in order.
- Loader write then read: write 0xDEADBEEF to 0x0400010, then read 0x0400010 in the next cycle -> write rsp data=0 err=0; read rsp data=0xDEADBEEF.
- Contention: both requesters valid for 4 cycles after reset, ld_lock=0 -> grants alternate fetch, ld, fetch, ld; each response appears 1 cycle after its grant on the correct port only.
- Range checks:
  - Loader write to 0x0400200 (one past the end) -> mem_we stays 0; ld_rsp_err=1, data=0.
  - Fetch 0x03FFFFF -> fetch_rsp_err=1.
- ld_lock asserted during fetch streaming -> fetch_req_ready drops that cycle; the already-granted fetch response is still delivered; fetch resumes when ld_lock=0.
- Assert rst_n low the cycle after a grant -> no response is issued; all response outputs are 0; the first contested grant after release goes to fetch. With IMEM_ARB_STATS_EN, counters read 0.
